// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the issue-mode encodings, valid strobe levels, bus widths, the
// reset fetch address, the buffer look-ahead margin, the FSM state type,
// and the record kept for each in-flight ICache request.
package inst_fetch_ctrl_pkg;

  localparam int InstBusWidth     = 32;
  localparam int InstAddrBusWidth = 32;

  localparam logic SingleIssue = 1'b0;
  localparam logic DualIssue   = 1'b1;

  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;

  localparam logic [InstAddrBusWidth-1:0] DefaultResetPc = 32'hBFC0_0000;

  // The buffer raises full four entries early, so fetch credit keeps this many in reserve.
  localparam int FullMargin = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrBusWidth-1:0] base;
    logic [1:0]                  width;
  } fetch_req_t;

  // An address in the upper word of an 8-byte pair fetches one instruction.
  // Any other address fetches the pair.
  function automatic logic [1:0] reqWidth(input logic [InstAddrBusWidth-1:0] pc);
    return pc[2] ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/fetch_req_fifo.sv
// Small synchronous FIFO that remembers the base address and width of every
// ICache request still waiting for its response.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push_i         store push_data_i at the tail
//   push_data_i    {base, width} of the request just accepted
//   pop_i          discard the head entry (ignored when empty)
//   head_o         oldest entry
//   count_o        number of stored entries
//   empty_o        FIFO holds no entries
//   full_o         FIFO holds DEPTH entries
module fetch_req_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  fetch_req_t                   push_data_i,
  input  logic                         pop_i,
  output fetch_req_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH+1);

  fetch_req_t      mem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q;
  logic [PtrW-1:0] rdPtr_q;
  logic [CntW-1:0] cnt_q;
  logic            doPush;
  logic            doPop;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // When full, a push is still accepted in a cycle that also pops the head.
  always_comb begin
    doPop  = pop_i & ~empty_o;
    doPush = push_i & (~full_o | doPop);
  end

  // This block updates storage, pointers and occupancy together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= push_data_i;
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (doPop) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      case ({doPush, doPop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer between the PC/redirect logic, the ICache and the
// instruction buffer. It issues fetches of one or two instructions and only
// requests when the buffer has room for everything in flight. After a
// redirect it discards stale ICache responses.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   flush, flush_pc_i            redirect and its new fetch address
//   issue_i, issue_mode_i        buffer pops this cycle (one, or two when dual)
//   icache_req_o/_ready_i        request handshake
//   icache_addr_o                fetch address
//   icache_resp_valid_i          in-order response with icache_inst1_i/2_i
//   icache_inst{1,2}_{addr,,valid}_o  push port of the instruction buffer
//   fetch_busy_o                 draining or requests still in flight
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DefaultResetPc,
  parameter int          BUF_DEPTH       = 16,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc_i,
  input  logic        issue_i,
  input  logic        issue_mode_i,
  output logic        icache_req_o,
  input  logic        icache_req_ready_i,
  output logic [31:0] icache_addr_o,
  input  logic        icache_resp_valid_i,
  input  logic [31:0] icache_inst1_i,
  input  logic [31:0] icache_inst2_i,
  output logic [31:0] icache_inst1_addr_o,
  output logic [31:0] icache_inst2_addr_o,
  output logic [31:0] icache_inst1_o,
  output logic [31:0] icache_inst2_o,
  output logic        icache_inst1_valid_o,
  output logic        icache_inst2_valid_o,
  output logic        fetch_busy_o
);

  localparam int OccW  = $clog2(BUF_DEPTH) + 1;
  localparam int CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PendW = $clog2(2 * MAX_OUTSTANDING + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [PendW-1:0] pend_q, pend_d;
  logic [CntW-1:0]  stale_q, stale_d;

  fetch_req_t       head;
  fetch_req_t       newReq;
  logic [CntW-1:0]  outstanding;
  logic             fifoEmpty;
  logic             fifoFull;

  logic             reqValid;
  logic             reqFire;
  logic             respAccept;
  logic             fwdValid;
  logic             inst2Valid;
  logic [1:0]       curWidth;
  logic [1:0]       pushed;
  logic [1:0]       popped;
  logic [31:0]      creditSum;
  logic [OccW:0]    occPlus;
  logic [CntW-1:0]  outAfter;

  fetch_req_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (reqFire),
    .push_data_i (newReq),
    .pop_i       (respAccept),
    .head_o      (head),
    .count_o     (outstanding),
    .empty_o     (fifoEmpty),
    .full_o      (fifoFull)
  );

  // This block makes the request, forwarding and credit decisions from registered state.
  // A response with nothing in flight belongs to no request, so it is ignored.
  // Holding the request low while rst is low keeps every strobe quiet during reset.
  always_comb begin
    curWidth   = reqWidth(pc_q);
    newReq     = '{base: pc_q, width: curWidth};
    creditSum  = 32'(occ_q) + 32'(pend_q) + 32'd2;
    reqValid   = rst & (state_q == RUN) & ~flush & ~fifoFull &
                 (creditSum <= 32'(BUF_DEPTH - FullMargin));
    reqFire    = reqValid & icache_req_ready_i;
    respAccept = icache_resp_valid_i & ~fifoEmpty;
    fwdValid   = (state_q == RUN) & ~flush & respAccept;
    inst2Valid = fwdValid & (head.width == 2'd2);
    pushed     = {1'b0, fwdValid} + {1'b0, inst2Valid};
    popped     = issue_i ? ((issue_mode_i == DualIssue) ? 2'd2 : 2'd1) : 2'd0;
    occPlus    = {1'b0, occ_q} + (OccW+1)'(pushed);
    outAfter   = outstanding + CntW'(reqFire) - CntW'(respAccept);

    // An issue that would pop more than the buffer holds is a protocol error.
    // The count clamps at zero instead of wrapping.
    if (flush) begin
      occ_d = '0;
    end else if (occPlus < (OccW+1)'(popped)) begin
      occ_d = '0;
    end else begin
      occ_d = OccW'(occPlus - (OccW+1)'(popped));
    end

    pend_d = pend_q + PendW'(reqFire ? curWidth : 2'd0)
                    - PendW'(respAccept ? head.width : 2'd0);

    if (flush) begin
      pc_d = flush_pc_i;
    end else if (reqFire) begin
      pc_d = pc_q + ((curWidth == 2'd2) ? 32'd8 : 32'd4);
    end else begin
      pc_d = pc_q;
    end

    // In DRAIN nothing new is requested, so stale always equals the FIFO count.
    // A flush while draining therefore keeps the remaining stale count.
    state_d = state_q;
    stale_d = stale_q;
    if (flush) begin
      stale_d = outAfter;
      state_d = (outAfter != '0) ? DRAIN : RUN;
    end else if ((state_q == DRAIN) && respAccept) begin
      stale_d = stale_q - 1'b1;
      if (stale_q == CntW'(1)) begin
        state_d = RUN;
      end
    end
  end

  // This block registers the FSM state, fetch PC and credit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      occ_q   <= '0;
      pend_q  <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      stale_q <= stale_d;
    end
  end

  assign icache_req_o         = reqValid;
  assign icache_addr_o        = pc_q;
  assign icache_inst1_valid_o = fwdValid;
  assign icache_inst2_valid_o = inst2Valid;
  assign icache_inst1_addr_o  = head.base;
  assign icache_inst2_addr_o  = head.base + 32'd4;
  assign icache_inst1_o       = icache_inst1_i;
  assign icache_inst2_o       = icache_inst2_i;
  assign fetch_busy_o         = (state_q != RUN) | (outstanding != '0);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl.
// It first runs a fixed vector table through startup, credit exhaustion,
// flush/drain and flush-with-response, then a reset taken mid-drain.
// After that it runs randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam int BufDepth = 16;
  localparam int MaxOut   = 2;
  localparam int CreditLimit = BufDepth - FullMargin;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flushPc = '0;
  logic        issue = 1'b0;
  logic        issueMode = 1'b0;
  logic        reqO;
  logic        reqReady = 1'b0;
  logic [31:0] addrO;
  logic        respValid = 1'b0;
  logic [31:0] inst1In = '0;
  logic [31:0] inst2In = '0;
  logic [31:0] inst1AddrO, inst2AddrO, inst1O, inst2O;
  logic        inst1ValidO, inst2ValidO, busyO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(
    .RESET_PC        (32'hBFC0_0000),
    .BUF_DEPTH       (BufDepth),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .flush_pc_i           (flushPc),
    .issue_i              (issue),
    .issue_mode_i         (issueMode),
    .icache_req_o         (reqO),
    .icache_req_ready_i   (reqReady),
    .icache_addr_o        (addrO),
    .icache_resp_valid_i  (respValid),
    .icache_inst1_i       (inst1In),
    .icache_inst2_i       (inst2In),
    .icache_inst1_addr_o  (inst1AddrO),
    .icache_inst2_addr_o  (inst2AddrO),
    .icache_inst1_o       (inst1O),
    .icache_inst2_o       (inst2O),
    .icache_inst1_valid_o (inst1ValidO),
    .icache_inst2_valid_o (inst2ValidO),
    .fetch_busy_o         (busyO)
  );

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        iss;
    logic        rdy;
    logic        rsp;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eV1;
    logic        eV2;
    logic [31:0] eA1;
    logic        eBusy;
  } vec_t;

  typedef struct {
    logic [31:0] base;
    int          width;
  } mreq_t;

  vec_t  vecs [24];
  mreq_t mQ [$];
  logic [31:0] mPc;
  int    mOcc;
  bit    mDraining;

  function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic iss,
                              input logic rdy, input logic rsp, input logic eReq,
                              input logic [31:0] eAddr, input logic eV1, input logic eV2,
                              input logic [31:0] eA1, input logic eBusy);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.iss = iss; v.rdy = rdy; v.rsp = rsp;
    v.eReq = eReq; v.eAddr = eAddr; v.eV1 = eV1; v.eV2 = eV2; v.eA1 = eA1; v.eBusy = eBusy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInputs(input logic fl, input logic [31:0] fpc, input logic iss,
                             input logic md, input logic rdy, input logic rsp,
                             input logic [31:0] d1, input logic [31:0] d2);
    flush = fl; flushPc = fpc; issue = iss; issueMode = md;
    reqReady = rdy; respValid = rsp; inst1In = d1; inst2In = d2;
  endtask

  // Called at a falling edge; the checks run 1 ns later, and the task returns at the next falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    driveInputs(v.fl, v.fpc, v.iss, DualIssue, v.rdy, v.rsp, d1, d2);
    #1;
    checkOutput($sformatf("vec%0d_req", idx), {31'b0, reqO}, {31'b0, v.eReq});
    if (v.eReq) checkOutput($sformatf("vec%0d_addr", idx), addrO, v.eAddr);
    checkOutput($sformatf("vec%0d_v1", idx), {31'b0, inst1ValidO}, {31'b0, v.eV1});
    checkOutput($sformatf("vec%0d_v2", idx), {31'b0, inst2ValidO}, {31'b0, v.eV2});
    if (v.eV1) begin
      checkOutput($sformatf("vec%0d_a1", idx), inst1AddrO, v.eA1);
      checkOutput($sformatf("vec%0d_d1", idx), inst1O, d1);
    end
    if (v.eV2) begin
      checkOutput($sformatf("vec%0d_a2", idx), inst2AddrO, v.eA1 + 32'd4);
      checkOutput($sformatf("vec%0d_d2", idx), inst2O, d2);
    end
    checkOutput($sformatf("vec%0d_busy", idx), {31'b0, busyO}, {31'b0, v.eBusy});
    @(negedge clk);
  endtask

  // One randomized cycle: predict outputs from the model, compare, then advance the model.
  task automatic randomCycle(input int cyc);
    logic fl, iss, md, rdy, rsp, eReq, eV1, eV2;
    logic [31:0] fpc, d1, d2;
    int popped, pend, pushed, w;
    fl  = ($urandom_range(0, 24) == 0);
    fpc = $urandom & 32'hFFFF_FFFC;
    md  = 1'($urandom_range(0, 1));
    iss = 1'($urandom_range(0, 1));
    popped = iss ? (md ? 2 : 1) : 0;
    if (popped > mOcc) begin
      iss = 1'b0;
      popped = 0;
    end
    rdy = ($urandom_range(0, 3) != 0);
    rsp = (mQ.size() != 0) && ($urandom_range(0, 2) != 0);
    d1  = $urandom;
    d2  = $urandom;
    driveInputs(fl, fpc, iss, md, rdy, rsp, d1, d2);
    #1;
    pend = 0;
    foreach (mQ[i]) pend += mQ[i].width;
    eReq = !mDraining && !fl && (mQ.size() < MaxOut) && (mOcc + pend + 2 <= CreditLimit);
    eV1  = rsp && !mDraining && !fl;
    eV2  = 1'b0;
    if (eV1) eV2 = (mQ[0].width == 2);
    checkOutput($sformatf("rnd%0d_req", cyc), {31'b0, reqO}, {31'b0, eReq});
    if (eReq) checkOutput($sformatf("rnd%0d_addr", cyc), addrO, mPc);
    checkOutput($sformatf("rnd%0d_v1", cyc), {31'b0, inst1ValidO}, {31'b0, eV1});
    checkOutput($sformatf("rnd%0d_v2", cyc), {31'b0, inst2ValidO}, {31'b0, eV2});
    if (eV1) begin
      checkOutput($sformatf("rnd%0d_a1", cyc), inst1AddrO, mQ[0].base);
      checkOutput($sformatf("rnd%0d_d1", cyc), inst1O, d1);
    end
    if (eV2) begin
      checkOutput($sformatf("rnd%0d_a2", cyc), inst2AddrO, mQ[0].base + 32'd4);
      checkOutput($sformatf("rnd%0d_d2", cyc), inst2O, d2);
    end
    checkOutput($sformatf("rnd%0d_busy", cyc), {31'b0, busyO},
                {31'b0, (mDraining || mQ.size() != 0)});

    pushed = (eV1 ? 1 : 0) + (eV2 ? 1 : 0);
    if (rsp) void'(mQ.pop_front());
    w = ((mPc % 8) == 4) ? 1 : 2;
    if (eReq && rdy) mQ.push_back('{base: mPc, width: w});
    if (fl) begin
      mPc = fpc;
      mOcc = 0;
      mDraining = (mQ.size() != 0);
    end else begin
      if (eReq && rdy) mPc = mPc + 32'(w * 4);
      mOcc = mOcc + pushed - popped;
      if (mDraining && mQ.size() == 0) mDraining = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 1, 0, 1, 32'hBFC0_0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 1, 32'hBFC0_0008, 1, 1, 32'hBFC0_0000, 1);
    vecs[2]  = mk(0, 0, 0, 1, 1, 1, 32'hBFC0_0010, 1, 1, 32'hBFC0_0008, 1);
    vecs[3]  = mk(0, 0, 0, 1, 1, 1, 32'hBFC0_0018, 1, 1, 32'hBFC0_0010, 1);
    vecs[4]  = mk(0, 0, 0, 1, 1, 1, 32'hBFC0_0020, 1, 1, 32'hBFC0_0018, 1);
    vecs[5]  = mk(0, 0, 0, 1, 1, 1, 32'hBFC0_0028, 1, 1, 32'hBFC0_0020, 1);
    vecs[6]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 32'hBFC0_0028, 1);
    vecs[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 1, 32'hBFC0_0030, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(0, 0, 1, 1, 0, 1, 32'hBFC0_0038, 0, 0, 0, 1);
    vecs[12] = mk(1, 32'h8000_0004, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 1, 0, 1, 32'h8000_0004, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 1, 1, 1, 32'h8000_0008, 1, 0, 32'h8000_0004, 1);
    vecs[18] = mk(0, 0, 0, 0, 1, 1, 32'h8000_0010, 1, 1, 32'h8000_0008, 1);
    vecs[19] = mk(0, 0, 0, 1, 0, 1, 32'h8000_0010, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 1, 0, 1, 32'h8000_0018, 0, 0, 0, 1);
    vecs[21] = mk(1, 32'h0000_1000, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 32'h0000_1000, 0, 0, 0, 0);

    // During reset a stray response must not produce strobes.
    driveInputs(0, 0, 0, 0, 1, 1, 32'h1111_1111, 32'h2222_2222);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", {31'b0, reqO}, 32'd0);
    checkOutput("rst_addr", addrO, 32'hBFC0_0000);
    checkOutput("rst_v1", {31'b0, inst1ValidO}, 32'd0);
    checkOutput("rst_busy", {31'b0, busyO}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) applyStimulus(vecs[i], i);

    $display("[TB] reset during drain");
    applyStimulus(mk(0, 0, 0, 1, 0, 1, 32'h0000_1000, 0, 0, 0, 0), 100);
    applyStimulus(mk(0, 0, 0, 1, 0, 1, 32'h0000_1008, 0, 0, 0, 1), 101);
    applyStimulus(mk(1, 32'h0000_2000, 0, 1, 0, 0, 0, 0, 0, 0, 1), 102);
    applyStimulus(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), 103);
    driveInputs(0, 0, 0, 0, 1, 1, 32'h3333_3333, 32'h4444_4444);
    rst = 1'b0;
    #1;
    checkOutput("middrain_req", {31'b0, reqO}, 32'd0);
    checkOutput("middrain_addr", addrO, 32'hBFC0_0000);
    checkOutput("middrain_v1", {31'b0, inst1ValidO}, 32'd0);
    checkOutput("middrain_v2", {31'b0, inst2ValidO}, 32'd0);
    checkOutput("middrain_busy", {31'b0, busyO}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // A late response after reset is ignored; ready stays low so state remains at reset values.
    applyStimulus(mk(0, 0, 0, 0, 1, 1, 32'hBFC0_0000, 0, 0, 0, 0), 104);

    $display("[TB] randomized traffic");
    mPc = 32'hBFC0_0000;
    mOcc = 0;
    mDraining = 1'b0;
    mQ.delete();
    for (int c = 0; c < 3000; c++) randomCycle(c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
